// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX write port among requesters.
// Grants last for a whole message or MAX_BURST bytes, optional idle gap.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic                          uart_clk,
   input  logic                          uart_rst,
   input  logic                          sched_en,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          wr_en,
   input  logic                          wr_full,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(MAX_BURST + 1);
   localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;
   logic [IDW-1:0]  rr_last_q, rr_last_d;
   logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

   logic [IDW-1:0]        pick;
   logic                  found;
   logic                  sel_valid;
   logic                  sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  grant_end;

   // Search for the first valid requester after the last one served
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!found && req_valid[IDW'((int'(rr_last_q) + i) % NUM_REQ)]) begin
            found = 1'b1;
            pick  = IDW'((int'(rr_last_q) + i) % NUM_REQ);
         end
      end
   end

   // Route the granted requester straight through to the write port
   always_comb begin
      sel_valid = req_valid[grant_id_q];
      sel_last  = req_last[grant_id_q];
      sel_data  = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      req_ready = '0;
      wr_en     = 1'b0;
      wr_data   = '0;
      if (state_q == XFER) begin
         req_ready[grant_id_q] = !wr_full;
         wr_en                 = sel_valid && !wr_full;
         wr_data               = sel_data;
      end
      grant_end = wr_en && (sel_last || (byte_cnt_q == CW'(MAX_BURST - 1)));
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q != IDLE);

   // Next-state: arbitrate in IDLE, count bytes in XFER, count down in GAP
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_last_d  = rr_last_q;
      byte_cnt_d = byte_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (sched_en && found) begin
               grant_id_d = pick;
               byte_cnt_d = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            if (grant_end) begin
               rr_last_d  = grant_id_q;
               byte_cnt_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = GW'(GAP_CYCLES - 1);
               end else begin
                  state_d = IDLE;
               end
            end else if (wr_en) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any partial message
   always_ff @(posedge uart_clk or posedge uart_rst) begin
      if (uart_rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_last_q  <= IDW'(NUM_REQ - 1);
         byte_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_last_q  <= rr_last_d;
         byte_cnt_q <= byte_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART TX path write interface among NUM_REQ requesters (e.g. CPU register port, DMA, debug console).
- Grants one requester at a time for a whole message, delimited by a last flag, capped at MAX_BURST bytes.
- Optionally inserts an idle gap between messages.
- Sits in the uart_clk domain, directly upstream of the TX path write port.

Parameters:
- NUM_REQ, 2, number of requesters; must be >= 2.
- DATA_WIDTH, 8, byte width.
- MAX_BURST, 16, maximum bytes per grant before forced re-arbitration; must be >= 1.
- GAP_CYCLES, 0, idle uart_clk cycles inserted after each grant ends; 0 means no gap state.

Ports:
- uart_clk  in  1  clock.
- uart_rst  in  1  asynchronous, active-high reset.
- sched_en  in  1  1 = new grants allowed; 0 = the in-flight grant completes and no new grant is issued.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final byte of a message.
- req_ready  out  NUM_REQ  per-requester accept.
- wr_data  out  DATA_WIDTH  to the TX path write data.
- wr_en  out  1  to the TX path write enable.
- wr_full  in  1  from the TX path full flag.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset values:
  - state = IDLE, grant_id = 0, rr_last = NUM_REQ-1, byte_cnt = 0, gap_cnt = 0.
  - req_ready = 0, wr_en = 0, wr_data = 0, busy = 0.
  - Reset is asynchronous and takes effect mid-message: the partial message is abandoned and no byte is written in the reset cycle.
- States: IDLE, XFER, GAP.
- IDLE:
  - If sched_en and any req_valid: choose the first set bit searching rr_last+1, rr_last+2, ... with wrap modulo NUM_REQ.
  - Register the choice into grant_id; set byte_cnt = 0; move to XFER on the next edge.
  - Arbitration latency is 1 cycle; no byte is accepted in IDLE.
- XFER:
  - req_ready[grant_id] = !wr_full. All other req_ready bits are 0.
  - wr_en = req_valid[grant_id] && !wr_full. This is combinational; bytes flow through with 0 latency.
  - wr_data = the grant_id slice of req_data when in XFER, else 0.
  - Each wr_en increments byte_cnt. byte_cnt width is $clog2(MAX_BURST+1).
  - The grant ends on a wr_en cycle where req_last[grant_id] = 1 or byte_cnt == MAX_BURST-1. At that point rr_last <= grant_id.
  - Next state after grant end is GAP if GAP_CYCLES > 0 (gap_cnt loaded with GAP_CYCLES-1), else IDLE.
  - If req_valid drops mid-message, the grant holds indefinitely; no timeout.
  - wr_full stalls without losing data; the requester holds data because req_ready = 0.
  - sched_en deassertion during XFER has no effect until the grant ends.
- GAP:
  - All req_ready = 0.
  - gap_cnt decrements each cycle; go to IDLE when gap_cnt == 0.
  - Total gap = GAP_CYCLES cycles.
- grant_id holds its value in IDLE and GAP. busy = 1 in XFER and GAP.
- Fairness:
  - A requester forced out by MAX_BURST drops to lowest priority, exactly as one finishing with req_last.
  - Its remaining bytes resume at its next grant; byte order per requester is preserved.
- Simultaneous req_last and byte_cnt == MAX_BURST-1: one grant end, not two.
- Back-to-back: with GAP_CYCLES = 0, minimum spacing between the last byte of one grant and the first byte of the next is 1 idle cycle (the IDLE arbitration cycle).

Test Plan:
- Reset, sched_en = 1, req 0 and req 1 both valid, 2-byte messages (0xA1,0xA2 last; 0xB1,0xB2 last): wr_en sequence A1,A2 then B1,B2; grant_id 0 then 1; exactly one IDLE cycle between grants.
- NUM_REQ = 4, all requesters continuously valid with single-byte last messages: grants cycle 0,1,2,3,0,1; each wr_data matches the granted requester.
- MAX_BURST = 4, req 2 sends a 10-byte message while req 0 is also valid: req 2 gets 4 bytes, req 0 gets its message, req 2 gets 4 more, and so on; req 2 bytes arrive in order 0x00..0x09.
- wr_full held high for 5 cycles mid-message: req_ready = 0 and wr_en = 0 for those cycles, byte_cnt is frozen, and no byte is lost or duplicated after release.
- GAP_CYCLES = 3: exactly 3 GAP cycles with busy = 1 after each grant ends, then IDLE; sched_en = 0 during XFER lets the current message finish and then blocks new grants (busy = 0, req_ready = 0).
- Assert uart_rst mid-XFER after 2 bytes: wr_en drops immediately and all outputs take reset values; after release with req 1 and req 0 valid, req 0 is granted first.
